// File: rtl/micro_seq_ctrl.sv
// micro_seq_ctrl: branch/wait/halt/interrupt control in front of a 12-bit microprogram sequencer
module micro_seq_ctrl #(
   parameter logic [11:0] VECTOR_IRQ   = 12'h010,
   parameter logic [11:0] VECTOR_ERR   = 12'h020,
   parameter int          STACK_DEPTH  = 4,
   parameter int          WAIT_TIMEOUT = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  i_uop,
   input  logic [2:0]  i_ucond,
   input  logic        i_upol,
   input  logic [11:0] i_uoffset,
   input  logic        i_uwait,
   input  logic        i_mem_ready,
   input  logic [6:0]  i_flags,
   input  logic        i_irq,
   input  logic        i_halt_req,
   input  logic [11:0] i_seq_addr,
   output logic [1:0]  o_seq_op,
   output logic [11:0] o_seq_din,
   output logic        o_exec_en,
   output logic        o_irq_ack,
   output logic        o_halted,
   output logic        o_stack_err,
   output logic        o_timeout,
   output logic [2:0]  o_depth
);
   typedef enum logic {S_RUN, S_HALT} state_t;
   localparam logic [2:0] LP_DEPTH = 3'(STACK_DEPTH);
   localparam logic [7:0] LP_TMO   = 8'(WAIT_TIMEOUT - 1);
   state_t      r_state, w_state_nxt;
   logic [11:0] r_last_addr;
   logic [2:0]  r_depth, w_depth_nxt;
   logic [7:0]  r_wcnt, w_wcnt_nxt;
   logic        r_stack_err, r_timeout, w_serr, w_tmo;
   logic [1:0]  w_op;
   logic [11:0] w_din;
   logic        w_exec, w_ack;
   // Slot 0 of the extended flag vector is the "always true" condition.
   logic [7:0]  w_flags_ext;
   logic        w_cond, w_wait, w_stk;
   logic [11:0] w_vec_err, w_vec_irq;
   assign w_flags_ext = {i_flags, 1'b1};
   assign w_cond      = w_flags_ext[i_ucond] ^ i_upol;
   assign w_wait      = i_uwait & ~i_mem_ready;
   assign w_stk       = w_cond & ((i_uop == 2'd2 & r_depth == LP_DEPTH) | (i_uop == 2'd3 & r_depth == 3'd0));
   // Vectors are absolute targets converted to offsets from the sequencer pc (cur+1).
   assign w_vec_err   = VECTOR_ERR - r_last_addr - 12'd1;
   assign w_vec_irq   = VECTOR_IRQ - r_last_addr - 12'd1;
   // Per-cycle decision: halt hold, stack trap, wait hold/timeout, halt entry, irq, normal op.
   always_comb begin
      w_op        = 2'd0;
      w_din       = 12'd0;
      w_exec      = 1'b1;
      w_ack       = 1'b0;
      w_depth_nxt = r_depth;
      w_wcnt_nxt  = 8'd0;
      w_state_nxt = S_RUN;
      w_serr      = 1'b0;
      w_tmo       = 1'b0;
      if (r_state == S_HALT && i_halt_req) begin
         w_op        = 2'd1;
         w_din       = 12'hFFF;
         w_exec      = 1'b0;
         w_state_nxt = S_HALT;
      end else if (w_stk) begin
         w_op   = 2'd1;
         w_din  = w_vec_err;
         w_serr = 1'b1;
      end else if (w_wait) begin
         w_op       = 2'd1;
         w_exec     = 1'b0;
         w_tmo      = r_wcnt == LP_TMO;
         w_din      = w_tmo ? w_vec_err : 12'hFFF;
         w_wcnt_nxt = w_tmo ? 8'd0 : r_wcnt + 8'd1;
      end else if (i_uop == 2'd0 && i_halt_req) begin
         w_op        = 2'd1;
         w_din       = 12'hFFF;
         w_exec      = 1'b0;
         w_state_nxt = S_HALT;
      end else if (i_uop == 2'd0 && i_irq && r_depth < LP_DEPTH) begin
         w_op        = 2'd2;
         w_din       = w_vec_irq;
         w_ack       = 1'b1;
         w_depth_nxt = r_depth + 3'd1;
      end else if (i_uop != 2'd0 && w_cond) begin
         w_op        = i_uop;
         w_din       = i_uop == 2'd3 ? 12'd0 : i_uoffset;
         w_depth_nxt = i_uop == 2'd2 ? r_depth + 3'd1 : i_uop == 2'd3 ? r_depth - 3'd1 : r_depth;
      end
   end
   // State, stack depth, wait counter and sticky error flags.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= S_RUN;
         r_last_addr <= 12'd0;
         r_depth     <= 3'd0;
         r_wcnt      <= 8'd0;
         r_stack_err <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_last_addr <= i_seq_addr;
         r_depth     <= w_depth_nxt;
         r_wcnt      <= w_wcnt_nxt;
         r_stack_err <= r_stack_err | w_serr;
         r_timeout   <= r_timeout | w_tmo;
      end
   end
   assign o_seq_op    = reset ? 2'd0 : w_op;
   assign o_seq_din   = reset ? 12'd0 : w_din;
   assign o_exec_en   = ~reset & w_exec;
   assign o_irq_ack   = ~reset & w_ack;
   assign o_halted    = r_state == S_HALT;
   assign o_stack_err = r_stack_err;
   assign o_timeout   = r_timeout;
   assign o_depth     = r_depth;
endmodule

// File: tb/tb_micro_seq_ctrl.sv
// tb_micro_seq_ctrl: directed scoreboard bench for micro_seq_ctrl with a behavioural sequencer
module tb_micro_seq_ctrl;
   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  uop;
   logic [2:0]  ucond;
   logic        upol;
   logic [11:0] uoffset;
   logic        uwait, mem_ready, irq, halt_req;
   logic [6:0]  flags;
   logic [11:0] seq_addr;
   logic [1:0]  seq_op;
   logic [11:0] seq_din;
   logic        exec_en, irq_ack, halted, stack_err, timeout;
   logic [2:0]  depth;
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [11:0] din;
      logic        ex, ack, hlt, serr, tmo;
      logic [2:0]  dep;
      logic [11:0] addr;
   } exp_t;
   exp_t q[$];
   exp_t mon_e;

   always #5 clock = ~clock;

   micro_seq_ctrl dut (
      .clock(clock), .reset(reset), .i_uop(uop), .i_ucond(ucond), .i_upol(upol),
      .i_uoffset(uoffset), .i_uwait(uwait), .i_mem_ready(mem_ready), .i_flags(flags),
      .i_irq(irq), .i_halt_req(halt_req), .i_seq_addr(seq_addr), .o_seq_op(seq_op),
      .o_seq_din(seq_din), .o_exec_en(exec_en), .o_irq_ack(irq_ack), .o_halted(halted),
      .o_stack_err(stack_err), .o_timeout(timeout), .o_depth(depth)
   );

   // Behavioural 12-bit sequencer with a 4-entry wrapping stack
   logic [11:0] sq_cur;
   logic [11:0] sq_stk [4];
   logic [1:0]  sq_sp;
   always_comb
      seq_addr = reset ? 12'd0 :
                 seq_op == 2'd0 ? sq_cur + 12'd1 :
                 seq_op == 2'd3 ? sq_stk[sq_sp - 2'd1] : sq_cur + 12'd1 + seq_din;
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         sq_cur <= 12'd0;
         sq_sp  <= 2'd0;
      end else begin
         sq_cur <= seq_addr;
         if (seq_op == 2'd2) begin
            sq_stk[sq_sp] <= sq_cur + 12'd1;
            sq_sp <= sq_sp + 2'd1;
         end else if (seq_op == 2'd3) begin
            sq_sp <= sq_sp - 2'd1;
         end
      end
   end

   // Monitor: pops one expectation per cycle it is due and compares
   always @(negedge clock) begin
      if (q.size() != 0) begin
         mon_e = q.pop_front();
         checks++;
         if (seq_op !== mon_e.op || ((mon_e.op == 2'd1 || mon_e.op == 2'd2) && seq_din !== mon_e.din) ||
             exec_en !== mon_e.ex || irq_ack !== mon_e.ack || halted !== mon_e.hlt ||
             stack_err !== mon_e.serr || timeout !== mon_e.tmo || depth !== mon_e.dep ||
             seq_addr !== mon_e.addr) begin
            errors++;
            $display("FAIL %s: got op=%0d din=%h ex=%b ack=%b hlt=%b serr=%b tmo=%b dep=%0d addr=%h ; want op=%0d din=%h ex=%b ack=%b hlt=%b serr=%b tmo=%b dep=%0d addr=%h",
                     mon_e.name, seq_op, seq_din, exec_en, irq_ack, halted, stack_err, timeout, depth, seq_addr,
                     mon_e.op, mon_e.din, mon_e.ex, mon_e.ack, mon_e.hlt, mon_e.serr, mon_e.tmo, mon_e.dep, mon_e.addr);
         end
      end
   end

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic set_in(input logic [1:0] op, input logic [2:0] cnd, input logic pol, input logic [11:0] off,
                         input logic wt, input logic rdy, input logic ir, input logic hr);
      uop = op; ucond = cnd; upol = pol; uoffset = off;
      uwait = wt; mem_ready = rdy; irq = ir; halt_req = hr;
   endtask

   task automatic expect_out(input string n, input logic [1:0] op, input logic [11:0] din, input logic ex,
                             input logic ack, input logic hlt, input logic serr, input logic tmo,
                             input logic [2:0] dep, input logic [11:0] addr);
      exp_t e;
      e.name = n; e.op = op; e.din = din; e.ex = ex; e.ack = ack; e.hlt = hlt;
      e.serr = serr; e.tmo = tmo; e.dep = dep; e.addr = addr;
      q.push_back(e);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      flags = 7'b0000100;
      set_in(2'd0, 3'd0, 1'b0, 12'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc();
      expect_out("reset", 2'd0, 12'h000, 0, 0, 0, 0, 0, 3'd0, 12'h000);
      cyc();
      reset = 1'b0;
      set_in(2'd1, 3'd0, 1'b0, 12'h03F, 1'b0, 1'b1, 1'b0, 1'b0);
      expect_out("jmp_to_040", 2'd1, 12'h03F, 1, 0, 0, 0, 0, 3'd0, 12'h040);
      cyc();
      set_in(2'd1, 3'd3, 1'b0, 12'h00F, 1'b0, 1'b1, 1'b0, 1'b0);
      expect_out("cond_jmp_taken", 2'd1, 12'h00F, 1, 0, 0, 0, 0, 3'd0, 12'h050);
      cyc();
      set_in(2'd1, 3'd0, 1'b0, 12'hFEF, 1'b0, 1'b1, 1'b0, 1'b0);
      expect_out("back_to_040", 2'd1, 12'hFEF, 1, 0, 0, 0, 0, 3'd0, 12'h040);
      cyc();
      set_in(2'd1, 3'd3, 1'b1, 12'h00F, 1'b0, 1'b1, 1'b0, 1'b0);
      expect_out("cond_jmp_inverted", 2'd0, 12'h000, 1, 0, 0, 0, 0, 3'd0, 12'h041);
      cyc();
      for (int i = 0; i < 3; i++) begin
         set_in(2'd0, 3'd0, 1'b0, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0);
         expect_out("wait_hold", 2'd1, 12'hFFF, 0, 0, 0, 0, 0, 3'd0, 12'h041);
         cyc();
      end
      mem_ready = 1'b1;
      expect_out("wait_done", 2'd0, 12'h000, 1, 0, 0, 0, 0, 3'd0, 12'h042);
      cyc();
      mem_ready = 1'b0;
      for (int i = 0; i < 254; i++) begin
         if (i == 0 || i == 253) expect_out("timeout_hold", 2'd1, 12'hFFF, 0, 0, 0, 0, 0, 3'd0, 12'h042);
         cyc();
      end
      expect_out("timeout_trap", 2'd1, 12'hFDD, 0, 0, 0, 0, 0, 3'd0, 12'h020);
      cyc();
      set_in(2'd0, 3'd0, 1'b0, 12'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      expect_out("timeout_flag", 2'd0, 12'h000, 1, 0, 0, 0, 1, 3'd0, 12'h021);
      cyc();
      for (int k = 0; k < 4; k++) begin
         set_in(2'd2, 3'd0, 1'b0, 12'd0, 1'b0, 1'b1, 1'b0, 1'b0);
         expect_out("call", 2'd2, 12'h000, 1, 0, 0, 0, 1, 3'(k), 12'h022 + 12'(k));
         cyc();
      end
      expect_out("call_overflow", 2'd1, 12'hFFA, 1, 0, 0, 0, 1, 3'd4, 12'h020);
      cyc();
      set_in(2'd0, 3'd0, 1'b0, 12'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      expect_out("stack_err_flag", 2'd0, 12'h000, 1, 0, 0, 1, 1, 3'd4, 12'h021);
      cyc();
      irq = 1'b1;
      expect_out("irq_stack_full", 2'd0, 12'h000, 1, 0, 0, 1, 1, 3'd4, 12'h022);
      cyc();
      for (int k = 0; k < 4; k++) begin
         set_in(2'd3, 3'd0, 1'b0, 12'd0, 1'b0, 1'b1, 1'b0, 1'b0);
         expect_out("return", 2'd3, 12'h000, 1, 0, 0, 1, 1, 3'(4 - k), 12'h025 - 12'(k));
         cyc();
      end
      set_in(2'd1, 3'd0, 1'b0, 12'h0DD, 1'b0, 1'b1, 1'b0, 1'b0);
      expect_out("jmp_to_100", 2'd1, 12'h0DD, 1, 0, 0, 1, 1, 3'd0, 12'h100);
      cyc();
      set_in(2'd0, 3'd0, 1'b0, 12'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      expect_out("irq_call", 2'd2, 12'hF0F, 1, 1, 0, 1, 1, 3'd0, 12'h010);
      cyc();
      irq = 1'b0;
      expect_out("irq_body", 2'd0, 12'h000, 1, 0, 0, 1, 1, 3'd1, 12'h011);
      cyc();
      uop = 2'd3;
      expect_out("irq_return", 2'd3, 12'h000, 1, 0, 0, 1, 1, 3'd1, 12'h101);
      cyc();
      uop = 2'd0;
      expect_out("after_return", 2'd0, 12'h000, 1, 0, 0, 1, 1, 3'd0, 12'h102);
      cyc();
      set_in(2'd0, 3'd0, 1'b0, 12'd0, 1'b0, 1'b1, 1'b1, 1'b1);
      expect_out("halt_enter", 2'd1, 12'hFFF, 0, 0, 0, 1, 1, 3'd0, 12'h102);
      cyc();
      for (int i = 0; i < 2; i++) begin
         expect_out("halt_hold", 2'd1, 12'hFFF, 0, 0, 1, 1, 1, 3'd0, 12'h102);
         cyc();
      end
      halt_req = 1'b0;
      expect_out("halt_release", 2'd2, 12'hF0D, 1, 1, 1, 1, 1, 3'd0, 12'h010);
      cyc();
      irq = 1'b0;
      expect_out("post_halt", 2'd0, 12'h000, 1, 0, 0, 1, 1, 3'd1, 12'h011);
      cyc();
      halt_req = 1'b1;
      expect_out("halt2_enter", 2'd1, 12'hFFF, 0, 0, 0, 1, 1, 3'd1, 12'h011);
      cyc();
      expect_out("halt2_hold", 2'd1, 12'hFFF, 0, 0, 1, 1, 1, 3'd1, 12'h011);
      cyc();
      reset = 1'b1;
      halt_req = 1'b0;
      expect_out("reset_in_halt", 2'd0, 12'h000, 0, 0, 0, 0, 0, 3'd0, 12'h000);
      cyc();
      reset = 1'b0;
      uop = 2'd3;
      expect_out("return_underflow", 2'd1, 12'h01F, 1, 0, 0, 0, 0, 3'd0, 12'h020);
      cyc();
      uop = 2'd0;
      expect_out("underflow_flag", 2'd0, 12'h000, 1, 0, 0, 1, 0, 3'd0, 12'h021);
      cyc();
      repeat (2) cyc();
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d expectations left, want 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
